// File: rtl/basic_control_unit.sv
// Fetch/decode/execute timing sequencer for the basic computer; drives ALU op select and datapath strobes.
// Optional macro CU_ISZ_EN adds the ISZ (D=6) memory-reference instruction; without it ISZ is illegal.
module basic_control_unit #(
  parameter int         SC_W     = 3,
  parameter logic [3:0] ALU_IDLE = 4'd15,
  parameter bit         BOOT_RUN = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [15:0]     Ir,
  input  logic [15:0]     Dr,
  input  logic            EO,
  input  logic            Incr,
  output logic [3:0]      St_Alu,
  output logic            EI,
  output logic [2:0]      Bus_Sel,
  output logic            Ar_Ld,
  output logic            Ar_Inc,
  output logic            Pc_Ld,
  output logic            Pc_Inc,
  output logic            Dr_Ld,
  output logic            Dr_Inc,
  output logic            Ac_Ld,
  output logic            Ir_Ld,
  output logic            Mem_Rd,
  output logic            Mem_Wr,
  output logic [SC_W-1:0] Sc,
  output logic            Halt,
  output logic            Illegal
);
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;
  localparam logic [SC_W-1:0] SC_LAST = '1;

  logic       e_q, i_q;
  logic       sc_clr, e_ld, halt_set, i_ld;
  logic [2:0] d;
  logic [3:0] rr_op;
  logic       rr_act, rr_hlt;

  assign d  = Ir[14:12];
  assign EI = e_q;

`ifndef CU_ISZ_EN
  logic unused_dr;
  assign unused_dr = ^Dr;
`endif

  // Register-reference decode: highest set bit of Ir[11:0] selects the single operation.
  always_comb begin
    rr_op  = 4'd0;
    rr_act = 1'b1;
    rr_hlt = 1'b0;
    casez (Ir[11:0])
      12'b1???_????_????: rr_op = 4'd6;
      12'b01??_????_????: rr_op = 4'd8;
      12'b001?_????_????: rr_op = 4'd3;
      12'b0001_????_????: rr_op = 4'd9;
      12'b0000_1???_????: rr_op = 4'd4;
      12'b0000_01??_????: rr_op = 4'd5;
      12'b0000_001?_????: rr_op = 4'd7;
      12'b0000_0001_????: rr_op = 4'd10;
      12'b0000_0000_1???: rr_op = 4'd11;
      12'b0000_0000_01??: rr_op = 4'd12;
      12'b0000_0000_001?: rr_op = 4'd13;
      12'b0000_0000_0001: begin rr_act = 1'b0; rr_hlt = 1'b1; end
      default:            rr_act = 1'b0;
    endcase
  end

  always_comb begin
    St_Alu   = ALU_IDLE;
    Bus_Sel  = BUS_NONE;
    Ar_Ld    = 1'b0;
    Ar_Inc   = 1'b0;
    Pc_Ld    = 1'b0;
    Pc_Inc   = 1'b0;
    Dr_Ld    = 1'b0;
    Dr_Inc   = 1'b0;
    Ac_Ld    = 1'b0;
    Ir_Ld    = 1'b0;
    Mem_Rd   = 1'b0;
    Mem_Wr   = 1'b0;
    Illegal  = 1'b0;
    sc_clr   = 1'b0;
    e_ld     = 1'b0;
    halt_set = 1'b0;
    i_ld     = 1'b0;
    if (rst_n && !Halt) begin
      case (int'(Sc))
        0: begin Bus_Sel = BUS_PC; Ar_Ld = 1'b1; end
        1: begin Mem_Rd = 1'b1; Bus_Sel = BUS_MEM; Ir_Ld = 1'b1; Pc_Inc = 1'b1; end
        2: begin Bus_Sel = BUS_IR; Ar_Ld = 1'b1; i_ld = 1'b1; end
        3: begin
          if (d == 3'd7) begin
            sc_clr = 1'b1;
            if (i_q) begin
              Illegal = 1'b1;
            end else begin
              halt_set = rr_hlt;
              if (rr_act) begin
                St_Alu = rr_op;
                Ac_Ld  = rr_op inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
                e_ld   = rr_op inside {4'd4, 4'd5, 4'd8, 4'd9};
                Pc_Inc = Incr && (rr_op inside {4'd10, 4'd11, 4'd12, 4'd13});
              end
            end
          end else if (i_q) begin
            Mem_Rd = 1'b1; Bus_Sel = BUS_MEM; Ar_Ld = 1'b1;
          end
        end
        4: begin
          case (d)
            3'd0, 3'd1, 3'd2: begin Mem_Rd = 1'b1; Bus_Sel = BUS_MEM; Dr_Ld = 1'b1; end
            3'd3: begin Mem_Wr = 1'b1; Bus_Sel = BUS_AC; sc_clr = 1'b1; end
            3'd4: begin Bus_Sel = BUS_AR; Pc_Ld = 1'b1; sc_clr = 1'b1; end
            3'd5: begin Mem_Wr = 1'b1; Bus_Sel = BUS_PC; Ar_Inc = 1'b1; end
`ifdef CU_ISZ_EN
            3'd6: begin Mem_Rd = 1'b1; Bus_Sel = BUS_MEM; Dr_Ld = 1'b1; end
`else
            3'd6: begin Illegal = 1'b1; sc_clr = 1'b1; end
`endif
            default: sc_clr = 1'b1;
          endcase
        end
        5: begin
          case (d)
            3'd0, 3'd1, 3'd2: begin
              St_Alu = {1'b0, d}; Ac_Ld = 1'b1; e_ld = (d == 3'd1); sc_clr = 1'b1;
            end
            3'd5: begin Bus_Sel = BUS_AR; Pc_Ld = 1'b1; sc_clr = 1'b1; end
`ifdef CU_ISZ_EN
            3'd6: Dr_Inc = 1'b1;
`endif
            default: sc_clr = 1'b1;
          endcase
        end
`ifdef CU_ISZ_EN
        6: begin
          if (d == 3'd6) begin
            Mem_Wr = 1'b1; Bus_Sel = BUS_DR; Pc_Inc = (Dr == 16'h0000);
          end
          sc_clr = 1'b1;
        end
`endif
        default: sc_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sc   <= '0;
      e_q  <= 1'b0;
      i_q  <= 1'b0;
      Halt <= !BOOT_RUN;
    end else if (Halt) begin
      Sc <= '0;
      if (Start) Halt <= 1'b0;
    end else begin
      Sc <= sc_clr ? '0 : Sc + SC_W'(1);
      if (e_ld)     e_q  <= EO;
      if (i_ld)     i_q  <= Ir[15];
      if (halt_set) Halt <= 1'b1;
    end
  end

  // Every instruction path clears Sc explicitly; hitting the top count means a missing clear.
  assert property (@(posedge clk) disable iff (!rst_n) Sc != SC_LAST);
endmodule
